demux_1to2_buf: RTL and testbench

DEMUX_1TO2_BUF -- requirements
Module: demux_1to2_buf

---
 rtl/demux_1to2_buf_if.sv | 26 ++
 rtl/demux_1to2_buf.sv | 72 +++++++
 tb/tb_demux_1to2_buf.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/demux_1to2_buf_if.sv
// Bundles the upstream handshake, two downstream ports and occupancy counts of demux_1to2_buf.
// slave = the demux itself; master = whatever drives upstream and sinks both ports.
interface demux_1to2_buf_if #(parameter int size = 32);
    logic [size-1:0] data_i;
    logic            select_i;
    logic            valid_i;
    logic            ready_o;
    logic [size-1:0] data0_o;
    logic            valid0_o;
    logic            ready0_i;
    logic [size-1:0] data1_o;
    logic            valid1_o;
    logic            ready1_i;
    logic [1:0]      count0_o;
    logic [1:0]      count1_o;

    modport slave (
        input  data_i, select_i, valid_i, ready0_i, ready1_i,
        output ready_o, data0_o, valid0_o, data1_o, valid1_o, count0_o, count1_o
    );

    modport master (
        output data_i, select_i, valid_i, ready0_i, ready1_i,
        input  ready_o, data0_o, valid0_o, data1_o, valid1_o, count0_o, count1_o
    );
endinterface

// File: rtl/demux_1to2_buf.sv
// 1-to-2 demux with a 2-deep FIFO per port; accept-to-valid latency 1 cycle.
// ready_o drops only when the selected port's FIFO is full; it never looks at downstream ready.
module demux_1to2_buf #(
    parameter int size = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    demux_1to2_buf_if.slave   bus
);

    logic [size-1:0] mem_q [2][2];
    logic [size-1:0] mem_d [2][2];
    logic [1:0]      rd_ptr_q, rd_ptr_d;
    logic [1:0]      wr_ptr_q, wr_ptr_d;
    logic [1:0]      cnt_q [2];
    logic [1:0]      cnt_d [2];
    logic [1:0]      push;
    logic [1:0]      pop;
    logic            ready;

    always_comb begin
        ready   = rst_i && (bus.select_i ? (cnt_q[1] < 2'd2) : (cnt_q[0] < 2'd2));
        push[0] = bus.valid_i & ready & ~bus.select_i;
        push[1] = bus.valid_i & ready &  bus.select_i;
        pop[0]  = (cnt_q[0] != 2'd0) & bus.ready0_i;
        pop[1]  = (cnt_q[1] != 2'd0) & bus.ready1_i;

        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        for (int k = 0; k < 2; k++) begin
            if (push[k]) begin
                mem_d[k][wr_ptr_q[k]] = bus.data_i;
                wr_ptr_d[k]           = ~wr_ptr_q[k];
            end
            // Popped entries are zeroed so the head slot of an empty FIFO reads as 0.
            // Push and pop never hit the same slot: push needs count<2, pop needs count>0.
            if (pop[k]) begin
                mem_d[k][rd_ptr_q[k]] = '0;
                rd_ptr_d[k]           = ~rd_ptr_q[k];
            end
            cnt_d[k] = cnt_q[k] + {1'b0, push[k]} - {1'b0, pop[k]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 0; k < 2; k++) begin
                mem_q[k][0] <= '0;
                mem_q[k][1] <= '0;
                cnt_q[k]    <= 2'd0;
            end
            rd_ptr_q <= 2'b00;
            wr_ptr_q <= 2'b00;
        end else begin
            mem_q    <= mem_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    assign bus.ready_o  = ready;
    assign bus.valid0_o = (cnt_q[0] != 2'd0);
    assign bus.valid1_o = (cnt_q[1] != 2'd0);
    assign bus.data0_o  = mem_q[0][rd_ptr_q[0]];
    assign bus.data1_o  = mem_q[1][rd_ptr_q[1]];
    assign bus.count0_o = cnt_q[0];
    assign bus.count1_o = cnt_q[1];

endmodule

// File: tb/tb_demux_1to2_buf.sv
// Directed bench for demux_1to2_buf: inputs driven and outputs sampled on the falling edge.
module tb_demux_1to2_buf;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    demux_1to2_buf_if #(.size(32)) bus ();

    demux_1to2_buf #(.size(32)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic sel, input logic [31:0] d);
        bus.valid_i  = v;
        bus.select_i = sel;
        bus.data_i   = d;
        #1;
    endtask

    initial begin
        bus.ready0_i = 1'b0;
        bus.ready1_i = 1'b0;
        drive(1'b1, 1'b0, 32'hDEAD_BEEF);

        // held in reset
        chk("rst_ready", {31'd0, bus.ready_o}, 32'd0);
        chk("rst_valid0", {31'd0, bus.valid0_o}, 32'd0);
        chk("rst_valid1", {31'd0, bus.valid1_o}, 32'd0);
        chk("rst_data0", bus.data0_o, 32'd0);
        chk("rst_data1", bus.data1_o, 32'd0);
        chk("rst_count0", {30'd0, bus.count0_o}, 32'd0);
        chk("rst_count1", {30'd0, bus.count1_o}, 32'd0);
        step();
        chk("rst_count0_clk", {30'd0, bus.count0_o}, 32'd0);

        // first push right after reset release
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 32'hA5A5_A5A5);
        chk("p0_ready_first", {31'd0, bus.ready_o}, 32'd1);
        step();
        drive(1'b0, 1'b0, 32'd0);
        chk("p0_valid0", {31'd0, bus.valid0_o}, 32'd1);
        chk("p0_data0", bus.data0_o, 32'hA5A5_A5A5);
        chk("p0_count0", {30'd0, bus.count0_o}, 32'd1);
        chk("p0_valid1", {31'd0, bus.valid1_o}, 32'd0);
        chk("p0_data1", bus.data1_o, 32'd0);

        // simultaneous push and pop at count 1
        bus.ready0_i = 1'b1;
        drive(1'b1, 1'b0, 32'h9);
        chk("pp_ready", {31'd0, bus.ready_o}, 32'd1);
        step();
        drive(1'b0, 1'b0, 32'd0);
        chk("pp_count0", {30'd0, bus.count0_o}, 32'd1);
        chk("pp_data0", bus.data0_o, 32'h9);
        step();
        chk("pp_drain_count0", {30'd0, bus.count0_o}, 32'd0);
        chk("pp_drain_valid0", {31'd0, bus.valid0_o}, 32'd0);
        chk("pp_drain_data0", bus.data0_o, 32'd0);
        step();
        chk("empty_pop_count0", {30'd0, bus.count0_o}, 32'd0);
        bus.ready0_i = 1'b0;

        // port 1 fills, third attempt stalls
        drive(1'b1, 1'b1, 32'h1);
        step();
        drive(1'b1, 1'b1, 32'h2);
        step();
        drive(1'b1, 1'b1, 32'h3);
        chk("p1_full_count", {30'd0, bus.count1_o}, 32'd2);
        chk("p1_full_ready", {31'd0, bus.ready_o}, 32'd0);
        step();
        chk("p1_stall_count", {30'd0, bus.count1_o}, 32'd2);
        chk("p1_stall_head", bus.data1_o, 32'h1);
        bus.ready1_i = 1'b1;
        #1;
        chk("p1_full_pop_ready", {31'd0, bus.ready_o}, 32'd0);
        step();
        chk("p1_out2_data", bus.data1_o, 32'h2);
        chk("p1_out2_count", {30'd0, bus.count1_o}, 32'd1);
        chk("p1_out2_ready", {31'd0, bus.ready_o}, 32'd1);
        step();
        drive(1'b0, 1'b0, 32'd0);
        chk("p1_out3_data", bus.data1_o, 32'h3);
        chk("p1_out3_count", {30'd0, bus.count1_o}, 32'd1);
        step();
        chk("p1_drain_valid", {31'd0, bus.valid1_o}, 32'd0);
        chk("p1_drain_data", bus.data1_o, 32'd0);
        bus.ready1_i = 1'b0;

        // port 0 full does not block port 1
        drive(1'b1, 1'b0, 32'h10);
        step();
        drive(1'b1, 1'b0, 32'h11);
        step();
        chk("p0_full_count", {30'd0, bus.count0_o}, 32'd2);
        chk("p0_full_ready_sel0", {31'd0, bus.ready_o}, 32'd0);
        drive(1'b1, 1'b1, 32'h7);
        chk("p0_full_ready_sel1", {31'd0, bus.ready_o}, 32'd1);
        step();
        drive(1'b0, 1'b0, 32'd0);
        chk("x_data1", bus.data1_o, 32'h7);
        chk("x_count1", {30'd0, bus.count1_o}, 32'd1);
        chk("x_data0", bus.data0_o, 32'h10);
        chk("x_count0", {30'd0, bus.count0_o}, 32'd2);

        // both full, reset between edges
        drive(1'b1, 1'b1, 32'h8);
        step();
        drive(1'b0, 1'b0, 32'd0);
        chk("both_full_count1", {30'd0, bus.count1_o}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid0", {31'd0, bus.valid0_o}, 32'd0);
        chk("mid_rst_valid1", {31'd0, bus.valid1_o}, 32'd0);
        chk("mid_rst_count0", {30'd0, bus.count0_o}, 32'd0);
        chk("mid_rst_count1", {30'd0, bus.count1_o}, 32'd0);
        chk("mid_rst_data0", bus.data0_o, 32'd0);
        chk("mid_rst_data1", bus.data1_o, 32'd0);
        chk("mid_rst_ready", {31'd0, bus.ready_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 32'h4);
        step();
        drive(1'b0, 1'b0, 32'd0);
        chk("post_rst_data0", bus.data0_o, 32'h4);
        chk("post_rst_count0", {30'd0, bus.count0_o}, 32'd1);
        chk("post_rst_count1", {30'd0, bus.count1_o}, 32'd0);
        bus.ready0_i = 1'b1;
        step();
        chk("post_rst_no_stale", bus.data0_o, 32'd0);
        chk("post_rst_empty", {30'd0, bus.count0_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
